// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one RV32I load/store at a time, applies
// sub-word store merging and load extension against an internal word array,
// and returns the result LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = XLEN / 8;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [XLEN-1:0]   rdata_reg, rdata_next;
    logic              error_reg, error_next;

    logic              write_reg;
    logic [XLEN-1:0]   addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [2:0]        funct3_reg;

    logic              accept;
    logic [1:0]        lane;
    logic [1:0]        size;
    logic              f3_illegal, misaligned, out_of_range, req_bad;
    logic [NB-1:0]     wr_be;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   rd_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_data;
    logic              mem_we;
    logic [AW-1:0]     wr_idx, rd_idx;

    assign accept    = (state_reg == S_IDLE) && req_valid;
    assign req_ready = (state_reg == S_IDLE);
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_error = error_reg;

    // State, latency counter and registered response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            error_reg <= error_next;
        end
    end

    // Capture the request fields on the accepting edge; held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg  <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            funct3_reg <= '0;
        end else if (accept) begin
            write_reg  <= req_write;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            funct3_reg <= req_funct3;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        error_next = error_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_next   = CNT_INIT;
                    state_next = (LATENCY == 1) ? S_EXEC : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                error_next = req_bad;
                rdata_next = (req_bad || write_reg) ? '0 : load_data;
                state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request decode: error causes, store lane enables/data, load extension.
    always_comb begin
        lane         = addr_reg[1:0];
        size         = funct3_reg[1:0];
        f3_illegal   = write_reg ? (funct3_reg > 3'd2)
                                 : ((funct3_reg == 3'd3) || (funct3_reg[2:1] == 2'b11));
        misaligned   = ((size == 2'b01) && addr_reg[0]) ||
                       ((size == 2'b10) && (addr_reg[1:0] != 2'b00));
        out_of_range = |addr_reg[XLEN-1:AW+2];
        req_bad      = f3_illegal || misaligned || out_of_range;
        byte_sel     = rd_word[{lane, 3'b000} +: 8];
        half_sel     = rd_word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00: begin
                wr_be     = NB'(1) << lane;
                wr_data   = {NB{wdata_reg[7:0]}};
                load_data = funct3_reg[2] ? {{(XLEN-8){1'b0}}, byte_sel}
                                          : {{(XLEN-8){byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wr_be     = lane[1] ? 4'b1100 : 4'b0011;
                wr_data   = {(NB/2){wdata_reg[15:0]}};
                load_data = funct3_reg[2] ? {{(XLEN-16){1'b0}}, half_sel}
                                          : {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            default: begin
                wr_be     = '1;
                wr_data   = wdata_reg;
                load_data = rd_word;
            end
        endcase
    end

    // Writes commit on the EXEC edge; the word is read on the accepting edge,
    // which is safe because no write can occur while a request is outstanding.
    assign mem_we = (state_reg == S_EXEC) && write_reg && !req_bad;
    assign wr_idx = addr_reg[AW+1:2];
    assign rd_idx = req_addr[AW+1:2];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            // One byte lane of the array: byte-enabled write, registered read.
            always_ff @(posedge clk) begin
                if (mem_we && wr_be[gi]) begin
                    mem_lane[wr_idx] <= wr_data[gi*8 +: 8];
                end
                if (accept) begin
                    rd_byte_reg <= mem_lane[rd_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, randomized
// traffic against a byte-addressed reference memory, backpressure, reset and
// single-cycle-latency throughput sequences.
module tb_dmem_responder;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT with LATENCY=2
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_error;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    // DUT with LATENCY=1
    logic        l1_req_valid, l1_req_ready, l1_req_write, l1_rsp_valid, l1_rsp_ready, l1_rsp_error;
    logic [31:0] l1_req_addr, l1_req_wdata, l1_rsp_rdata;
    logic [2:0]  l1_req_funct3;

    dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_funct3(l1_req_funct3),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready),
        .rsp_rdata(l1_rsp_rdata), .rsp_error(l1_rsp_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Byte-addressed reference memory (little-endian).
    logic [7:0] ref_mem [int unsigned];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Reference behaviour from the load/store rules; updates ref_mem on legal stores.
    function automatic void ref_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                       input logic [2:0] f3, output logic [31:0] rd, output bit err);
        int     nbytes;
        bit     legal;
        longint v;
        nbytes = 1 << f3[1:0];
        legal  = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        err    = !legal || ((addr % nbytes) != 0) || ((addr >> 2) >= DEPTH);
        rd     = 32'h0;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nbytes; i++) v = v | (longint'(ref_mem[addr + i]) << (8*i));
            if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v - (longint'(1) << (8*nbytes));
            rd = v[31:0];
        end
    endfunction

    // One full transaction on the LATENCY=2 DUT; entered and left at posedge+1.
    task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3, input int hold,
                          input logic [31:0] exp_rd, input bit exp_err);
        int          k;
        int          lat;
        logic [31:0] rd;
        logic        er;
        req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s accept: req_ready never rose, expected 1", name);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check32({name, " latency"}, lat, LAT);
        if (!rsp_valid) return;
        repeat (hold) begin @(posedge clk); #1; end
        rd = rsp_rdata; er = rsp_error;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check32({name, " rdata"}, rd, exp_rd);
        check32({name, " error"}, {31'b0, er}, {31'b0, exp_err});
        check32({name, " valid_drop"}, {31'b0, rsp_valid}, 32'h0);
        $display("txn %-12s wr=%0d addr=%08h f3=%0d rdata=%08h err=%0d lat=%0d",
                 name, wr, addr, f3, rd, er, lat);
    endtask

    initial begin
        logic [31:0] e_rd, e2_rd, d;
        bit          e_err;
        bit          wr;
        logic [31:0] a;
        logic [2:0]  f;
        int          lat;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e_rd, e2_rd, d, a;
        bit          e_err, wr;
        logic [2:0]  f;
        int          lat;

        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0; rsp_ready = 0;
        l1_req_valid = 0; l1_req_write = 0; l1_req_addr = 0; l1_req_wdata = 0; l1_req_funct3 = 0;
        l1_rsp_ready = 0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check32("reset req_ready", {31'b0, req_ready}, 32'h1);
        check32("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check32("reset rsp_rdata", rsp_rdata, 32'h0);
        check32("reset rsp_error", {31'b0, rsp_error}, 32'h0);
        $display("txn reset        outputs sampled");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- directed vector table ----------------
        tbl.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 3'd2, 32'h0,        1'b0}); // SW
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 1'b0}); // LW
        tbl.push_back('{1'b1, 32'h11,   32'h000000A5, 3'd0, 32'h0,        1'b0}); // SB
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADA5EF, 1'b0}); // LW
        tbl.push_back('{1'b0, 32'h11,   32'h0,        3'd0, 32'hFFFFFFA5, 1'b0}); // LB
        tbl.push_back('{1'b0, 32'h11,   32'h0,        3'd4, 32'h000000A5, 1'b0}); // LBU
        tbl.push_back('{1'b0, 32'h12,   32'h0,        3'd1, 32'hFFFFDEAD, 1'b0}); // LH
        tbl.push_back('{1'b0, 32'h12,   32'h0,        3'd5, 32'h0000DEAD, 1'b0}); // LHU
        tbl.push_back('{1'b0, 32'h12,   32'h0,        3'd2, 32'h0,        1'b1}); // LW misaligned
        tbl.push_back('{1'b1, 32'h13,   32'h0000FFFF, 3'd1, 32'h0,        1'b1}); // SH misaligned
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADA5EF, 1'b0}); // LW unchanged
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd3, 32'h0,        1'b1}); // funct3=3 load
        tbl.push_back('{1'b0, 32'h1000, 32'h0,        3'd2, 32'h0,        1'b1}); // word 1024
        tbl.push_back('{1'b0, 32'h4000, 32'h0,        3'd2, 32'h0,        1'b1}); // word 0x1000
        tbl.push_back('{1'b1, 32'hFFC,  32'h0BADF00D, 3'd2, 32'h0,        1'b0}); // last word
        tbl.push_back('{1'b0, 32'hFFC,  32'h0,        3'd2, 32'h0BADF00D, 1'b0});
        tbl.push_back('{1'b1, 32'h12,   32'hCC001234, 3'd1, 32'h0,        1'b0}); // SH upper half
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'h1234A5EF, 1'b0});
        tbl.push_back('{1'b1, 32'h10,   32'h11111111, 3'd3, 32'h0,        1'b1}); // illegal store
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'h1234A5EF, 1'b0});
        tbl.push_back('{1'b0, 32'h11,   32'h0,        3'd1, 32'h0,        1'b1}); // LH misaligned
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd6, 32'h0,        1'b1}); // funct3=6 load

        for (int i = 0; i < tbl.size(); i++) begin
            ref_access(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].f3, e_rd, e_err);
            do_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].f3,
                   i % 3, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // ---------------- randomized traffic vs reference model ----------------
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            ref_access(1'b1, 32'(w * 4), d, 3'd2, e_rd, e_err);
            do_txn($sformatf("init%0d", w), 1'b1, 32'(w * 4), d, 3'd2, 0, e_rd, e_err);
        end
        for (int n = 0; n < 150; n++) begin
            wr = ($urandom_range(0, 2) == 0);
            f  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 63));
            else if ($urandom_range(0, 1) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else a = $urandom | 32'h8000_0000;
            d = $urandom;
            ref_access(wr, a, d, f, e_rd, e_err);
            do_txn($sformatf("rnd%0d", n), wr, a, d, f, $urandom_range(0, 3), e_rd, e_err);
        end

        // ---------------- backpressure with req_valid held ----------------
        ref_access(1'b0, 32'h10, 32'h0, 3'd2, e_rd, e_err);
        ref_access(1'b0, 32'h14, 32'h0, 3'd2, e2_rd, e_err);
        req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2; req_valid = 1'b1;
        check32("bp first ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_addr = 32'h14;
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check32("bp first latency", lat, LAT);
        for (int c = 0; c < 5; c++) begin
            check32("bp hold valid", {31'b0, rsp_valid}, 32'h1);
            check32("bp hold rdata", rsp_rdata, e_rd);
            check32("bp hold error", {31'b0, rsp_error}, 32'h0);
            check32("bp hold req_ready", {31'b0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check32("bp release valid", {31'b0, rsp_valid}, 32'h0);
        check32("bp release idle", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check32("bp second accepted", {31'b0, req_ready}, 32'h0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check32("bp second latency", lat, LAT);
        check32("bp second rdata", rsp_rdata, e2_rd);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn backpressure second load rdata=%08h", e2_rd);

        // ---------------- reset during WAIT of a store ----------------
        ref_access(1'b1, 32'h20, 32'h0, 3'd2, e_rd, e_err);
        do_txn("rst_pre_sw", 1'b1, 32'h20, 32'h0, 3'd2, 0, e_rd, e_err);
        ref_access(1'b0, 32'h10, 32'h0, 3'd2, e_rd, e_err);
        do_txn("rst_pre_lw", 1'b0, 32'h10, 32'h0, 3'd2, 0, e_rd, e_err);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check32("async rst req_ready", {31'b0, req_ready}, 32'h1);
        check32("async rst rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check32("async rst rsp_rdata", rsp_rdata, 32'h0);
        check32("async rst rsp_error", {31'b0, rsp_error}, 32'h0);
        $display("txn reset_in_wait outputs sampled");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn("rst_post_lw", 1'b0, 32'h20, 32'h0, 3'd2, 0, 32'h0, 1'b0);

        // ---------------- LATENCY=1 back-to-back ----------------
        l1_req_write = 1'b1; l1_req_addr = 32'h0; l1_req_wdata = 32'hC0FFEE11;
        l1_req_funct3 = 3'd2; l1_req_valid = 1'b1; l1_rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            check32($sformatf("l1 req_ready c%0d", c), {31'b0, l1_req_ready},
                    (c % 3 == 0) ? 32'h1 : 32'h0);
            check32($sformatf("l1 rsp_valid c%0d", c), {31'b0, l1_rsp_valid},
                    (c % 3 == 2) ? 32'h1 : 32'h0);
            if (c == 5 || c == 8) check32($sformatf("l1 rdata c%0d", c), l1_rsp_rdata, 32'hC0FFEE11);
            $display("txn l1 cycle %0d req_ready=%0d rsp_valid=%0d rdata=%08h",
                     c, l1_req_ready, l1_rsp_valid, l1_rsp_rdata);
            if (c == 1) l1_req_write = 1'b0;
            @(posedge clk); #1;
        end
        l1_req_valid = 1'b0;
        l1_rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
